lfsr_keystream: RTL and testbench

Parametrised Fibonacci LFSR key generator and the successor of the fixed 8-bit key generator. It takes a seed key, then produces one new WIDTH-bit key per request by clocking the register STEPS times, and hands the key out with a one-cycle valid strobe. Tap positions, width and steps-per-key are parameters. All-zero seeds are replaced so the register cannot lock up. It sits between the key-entry logic (seed, load button) and the cipher datapath that consumes key_out.

---
 rtl/lfsr_keystream.sv | 134 +++++++++++++
 tb/tb_lfsr_keystream.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_keystream.sv
// rtl/lfsr_keystream.sv - Fibonacci LFSR key generator, one WIDTH-bit key per request
// A request clocks the register STEPS times and strobes the final state out as the next key.
module lfsr_keystream #(
   parameter int unsigned      WIDTH         = 8,
   parameter logic [WIDTH-1:0] TAPS          = WIDTH'('h18),
   parameter int unsigned      STEPS         = 8,
   parameter logic [WIDTH-1:0] SEED_FALLBACK = WIDTH'(1),
   parameter int unsigned      CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             req,
   output logic             busy,
   output logic             key_valid,
   output logic [WIDTH-1:0] key_out,
   output logic             zero_seed,
   output logic [CNT_W-1:0] key_count
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [15:0] LAST_STEP = 16'(STEPS - 1);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  lfsr_q, lfsr_d;
   logic [15:0]       step_q, step_d;
   logic [WIDTH-1:0]  key_out_q, key_out_d;
   logic              key_valid_q, key_valid_d;
   logic              zero_seed_q, zero_seed_d;
   logic [CNT_W-1:0]  key_count_q, key_count_d;

   logic              fb;
   logic [WIDTH-1:0]  lfsr_next;
   logic              seed_is_zero;
   logic [WIDTH-1:0]  load_value;
   logic              last_step;

   assign fb           = ^(lfsr_q & TAPS);
   assign lfsr_next    = {lfsr_q[WIDTH-2:0], fb};
   // An all-zero seed would lock the register, so it is swapped for the fallback.
   assign seed_is_zero = (seed == '0);
   assign load_value   = seed_is_zero ? SEED_FALLBACK : seed;
   assign last_step    = (step_q == LAST_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!load && req) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (load || last_step) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == S_RUN);
      key_valid = key_valid_q;
      key_out   = key_out_q;
      zero_seed = zero_seed_q;
      key_count = key_count_q;
   end

   // Load takes priority in both states; in RUN it abandons the key being built.
   always_comb begin
      lfsr_d      = lfsr_q;
      step_d      = step_q;
      key_out_d   = key_out_q;
      key_valid_d = 1'b0;
      zero_seed_d = zero_seed_q;
      key_count_d = key_count_q;
      if (load) begin
         lfsr_d      = load_value;
         zero_seed_d = seed_is_zero;
         key_count_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  step_d = '0;
               end
            end
            S_RUN: begin
               lfsr_d = lfsr_next;
               step_d = step_q + 16'd1;
               if (last_step) begin
                  key_out_d   = lfsr_next;
                  key_valid_d = 1'b1;
                  key_count_d = key_count_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q      <= SEED_FALLBACK;
         step_q      <= '0;
         key_out_q   <= '0;
         key_valid_q <= 1'b0;
         zero_seed_q <= 1'b0;
         key_count_q <= '0;
      end else begin
         lfsr_q      <= lfsr_d;
         step_q      <= step_d;
         key_out_q   <= key_out_d;
         key_valid_q <= key_valid_d;
         zero_seed_q <= zero_seed_d;
         key_count_q <= key_count_d;
      end
   end

endmodule

// File: tb/tb_lfsr_keystream.sv
// tb/tb_lfsr_keystream.sv - scoreboard bench for lfsr_keystream (default and 16-bit builds)
// Expected keys come from a bit-counting LFSR model and are matched by independent monitors.
module tb_lfsr_keystream;

   typedef struct {
      int key;
      int cnt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        load, req;
   logic [7:0]  seed;
   logic        busy, key_valid, zero_seed;
   logic [7:0]  key_out;
   logic [15:0] key_count;

   logic        load16, req16;
   logic [15:0] seed16;
   logic        busy16, kv16, zs16;
   logic [15:0] ko16;
   logic [7:0]  kc16;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   exp_t q8[$];
   exp_t q16[$];
   int   kv_times[$];
   bit   seen16[int];
   int   n16_keys = 0;
   int   m8 = 1, m8_cnt = 0;
   int   m16 = 0, m16_cnt = 0;
   int   last_key = 0;
   int   prev_kv = 0;
   int   prev_kv16 = 0;

   lfsr_keystream u_dut (
      .clk(clk), .rst(rst), .load(load), .seed(seed), .req(req),
      .busy(busy), .key_valid(key_valid), .key_out(key_out),
      .zero_seed(zero_seed), .key_count(key_count)
   );

   lfsr_keystream #(
      .WIDTH(16), .TAPS(16'hB400), .STEPS(1), .SEED_FALLBACK(16'h0001), .CNT_W(8)
   ) u_dut16 (
      .clk(clk), .rst(rst), .load(load16), .seed(seed16), .req(req16),
      .busy(busy16), .key_valid(kv16), .key_out(ko16),
      .zero_seed(zs16), .key_count(kc16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic int lfsr_adv(int v, int width, int taps, int n);
      int r;
      r = v;
      for (int s = 0; s < n; s++) begin
         int ones;
         ones = 0;
         for (int i = 0; i < width; i++)
            if (((taps >> i) & 1) == 1 && ((r >> i) & 1) == 1) ones++;
         r = ((r << 1) | (ones % 2)) & ((1 << width) - 1);
      end
      return r;
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (key_valid) begin
            check("kv_not_consecutive", prev_kv, 0);
            if (q8.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL kv_unexpected: key_valid with key 0x%0h but no key pending", key_out);
            end else begin
               exp_t e;
               e = q8.pop_front();
               check("key_out", int'(key_out), e.key);
               check("key_count", int'(key_count), e.cnt);
            end
            last_key = int'(key_out);
            kv_times.push_back(cyc);
         end else begin
            check("key_out_hold", int'(key_out), last_key);
         end
         prev_kv = int'(key_valid);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (kv16) begin
            check("kv16_not_consecutive", prev_kv16, 0);
            if (q16.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL kv16_unexpected: key_valid with key 0x%0h but no key pending", ko16);
            end else begin
               exp_t e;
               e = q16.pop_front();
               check("key16_out", int'(ko16), e.key);
               check("key16_count", int'(kc16), e.cnt);
            end
            check("key16_no_repeat", int'(seen16.exists(int'(ko16))), 0);
            seen16[int'(ko16)] = 1'b1;
            n16_keys++;
         end
         prev_kv16 = int'(kv16);
      end
   end

   task automatic push8;
      m8     = lfsr_adv(m8, 8, 'h18, 8);
      m8_cnt = (m8_cnt + 1) % 65536;
      q8.push_back('{m8, m8_cnt});
   endtask

   task automatic req8;
      int nb, guard;
      push8();
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      nb = 0;
      guard = 0;
      while (busy && guard < 100) begin
         nb++;
         guard++;
         @(negedge clk);
      end
      check("busy_cycles", nb, 8);
      check("kv_after_busy", int'(key_valid), 1);
      @(negedge clk);
   endtask

   task automatic load8(input int s);
      m8     = (s == 0) ? 1 : s;
      m8_cnt = 0;
      seed   = 8'(s);
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("zero_seed", int'(zero_seed), (s == 0) ? 1 : 0);
      check("count_after_load", int'(key_count), 0);
      check("busy_after_load", int'(busy), 0);
   endtask

   initial begin
      int base, s, saved;
      rst = 1'b1; load = 1'b0; req = 1'b0; seed = 8'h55;
      load16 = 1'b0; req16 = 1'b0; seed16 = 16'h0;
      repeat (2) begin
         @(negedge clk);
         load = ~load; req = ~req; load16 = ~load16; req16 = ~req16;
      end
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_key_valid", int'(key_valid), 0);
      check("rst_key_out", int'(key_out), 0);
      check("rst_zero_seed", int'(zero_seed), 0);
      check("rst_key_count", int'(key_count), 0);
      check("rst16_busy", int'(busy16), 0);
      check("rst16_key_count", int'(kc16), 0);
      rst = 1'b0; load = 1'b0; req = 1'b0; load16 = 1'b0; req16 = 1'b0;
      @(negedge clk);

      // Default seed after reset is the fallback 0x01.
      req8();
      check("first_key_after_rst", int'(key_out), 'h19);

      load8(1);
      req8();
      check("key_seed01", int'(key_out), 'h19);
      req8();
      check("key_second", int'(key_out), 'h5F);
      check("count_second", int'(key_count), 2);

      load8(0);
      req8();
      check("key_zero_seed", int'(key_out), 'h19);
      load8(1);

      // Abort on the fourth busy cycle.
      saved = int'(key_out);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", int'(busy), 1);
      seed = 8'h01; load = 1'b1;
      m8 = 1; m8_cnt = 0;
      @(negedge clk);
      load = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_kv", int'(key_valid), 0);
      check("abort_key_out", int'(key_out), saved);
      check("abort_count", int'(key_count), 0);
      repeat (12) @(negedge clk);
      req8();
      check("key_after_abort", int'(key_out), 'h19);

      // Back-to-back requests with req held high.
      base = kv_times.size();
      repeat (4) push8();
      req = 1'b1;
      repeat (30) @(negedge clk);
      req = 1'b0;
      repeat (15) @(negedge clk);
      check("b2b_key_total", kv_times.size() - base, 4);
      if (kv_times.size() - base == 4)
         for (int i = 0; i < 3; i++)
            check("b2b_gap", kv_times[base + i + 1] - kv_times[base + i], 9);

      // load and req together: load wins, no generation starts.
      s = $urandom_range(1, 255);
      m8 = s; m8_cnt = 0;
      seed = 8'(s); load = 1'b1; req = 1'b1;
      @(negedge clk);
      load = 1'b0; req = 1'b0;
      check("prec_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      check("prec_busy_later", int'(busy), 0);
      check("prec_count", int'(key_count), 0);
      req8();

      for (int it = 0; it < 12; it++) begin
         s = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255);
         load8(s);
         repeat ($urandom_range(1, 3)) req8();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // 16-bit build: one shift per key, key_count wraps at 256.
      seed16 = 16'hACE1; load16 = 1'b1;
      m16 = 'hACE1; m16_cnt = 0;
      @(negedge clk);
      load16 = 1'b0;
      m16 = lfsr_adv(m16, 16, 'hB400, 1);
      m16_cnt = (m16_cnt + 1) % 256;
      q16.push_back('{m16, m16_cnt});
      req16 = 1'b1;
      @(negedge clk);
      req16 = 1'b0;
      @(negedge clk);
      check("key16_first", int'(ko16), 'h59C3);
      for (int k = 0; k < 999; k++) begin
         m16 = lfsr_adv(m16, 16, 'hB400, 1);
         m16_cnt = (m16_cnt + 1) % 256;
         q16.push_back('{m16, m16_cnt});
      end
      req16 = 1'b1;
      repeat (1998) @(negedge clk);
      req16 = 1'b0;
      repeat (5) @(negedge clk);
      check("key16_total", n16_keys, 1000);

      check("q8_drained", q8.size(), 0);
      check("q16_drained", q16.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
